// File: rtl/poly1305_stream_if.sv
// ---------------------------------------------------------------------------
// poly1305_stream_if
//   Groups the key, message-block, abort and tag handshakes of the
//   poly1305_stream authenticator into one bundle.
//   master : the side that supplies key/message and takes the tag
//   slave  : the authenticator itself
// Signals
//   key_vld / key_r / key_s          key load (r and s halves, little-endian)
//   msg_vld / msg_rdy / msg          16-byte message block, little-endian
//   msg_len / msg_last               valid bytes in block (1..16), final block
//   abort                            drop current message and key
//   tag_vld / tag_rdy / tag          128-bit tag, little-endian
// ---------------------------------------------------------------------------
interface poly1305_stream_if;
    logic         key_vld;
    logic [127:0] key_r;
    logic [127:0] key_s;
    logic         msg_vld;
    logic         msg_rdy;
    logic [127:0] msg;
    logic [4:0]   msg_len;
    logic         msg_last;
    logic         abort;
    logic         tag_vld;
    logic         tag_rdy;
    logic [127:0] tag;

    modport master (
        output key_vld, key_r, key_s, msg_vld, msg, msg_len, msg_last, abort, tag_rdy,
        input  msg_rdy, tag_vld, tag
    );

    modport slave (
        input  key_vld, key_r, key_s, msg_vld, msg, msg_len, msg_last, abort, tag_rdy,
        output msg_rdy, tag_vld, tag
    );
endinterface

// File: rtl/poly1305_stream.sv
// ---------------------------------------------------------------------------
// poly1305_stream
//   Streaming Poly1305 one-time authenticator. A key (r, s) is loaded in
//   IDLE, then 16-byte blocks (the last one may be partial) are absorbed
//   through a digit-serial (acc+n)*r mod 2^130-5 engine, and the 128-bit tag
//   (acc + s) mod 2^128 is presented on a valid/ready port.
// Parameters
//   DIGIT_W  bits of r consumed per multiply cycle (1,2,4,8,16,32);
//            a block takes 128/DIGIT_W multiply cycles plus one fold cycle.
// Ports
//   clk       clock, all state on rising edge
//   rst_ni    synchronous active-low reset
//   p1305_if  slave side of poly1305_stream_if (key, message, abort, tag)
// ---------------------------------------------------------------------------
module poly1305_stream #(
    parameter int DIGIT_W = 8
) (
    input logic              clk,
    input logic              rst_ni,
    poly1305_stream_if.slave p1305_if
);

    localparam int MUL_CYC = 128 / DIGIT_W;
    localparam int CW      = $clog2(MUL_CYC + 1);
    // Width of one shift-and-accumulate step before folding.
    localparam int WIDE    = 132 + DIGIT_W;
    // Width of 5 * (bits above 2^130) of a step.
    localparam int FW      = DIGIT_W + 5;

    localparam logic [127:0]  R_CLAMP  = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [129:0]  P_MOD    = {{126{1'b1}}, 4'b1011};   // 2^130 - 5
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_MUL,
        S_FINAL,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [129:0]    acc_q;    // running accumulator, always < 2^130
    logic [127:0]    r_q;      // clamped r
    logic [127:0]    s_q;
    logic [127:0]    tag_q;
    logic [130:0]    a_q;      // acc + n for the block being multiplied
    logic [130:0]    p_q;      // partial product, kept < 2^131
    logic [127:0]    r_sh_q;   // r shifted left, top digit is the current one
    logic [CW-1:0]   cnt_q;
    logic            last_q;

    // ------------------------------------------------------------------
    // Block to integer: mask bytes beyond msg_len, then add 2^(8*msg_len)
    // ------------------------------------------------------------------
    logic [127:0] msg_masked;
    logic [128:0] msg_pad;
    logic [128:0] msg_n;
    logic [130:0] blk_sum;

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        assign msg_masked[gi*8 +: 8] = (5'(gi) < p1305_if.msg_len) ?
                                       p1305_if.msg[gi*8 +: 8] : 8'h00;
    end

    for (genvar gi = 0; gi < 129; gi++) begin : g_pad
        if ((gi % 8 == 0) && (gi != 0)) begin : g_on
            assign msg_pad[gi] = (p1305_if.msg_len == 5'(gi / 8));
        end else begin : g_off
            assign msg_pad[gi] = 1'b0;
        end
    end

    assign msg_n   = {1'b0, msg_masked} | msg_pad;
    assign blk_sum = {1'b0, acc_q} + {2'b00, msg_n};

    // ------------------------------------------------------------------
    // One multiply step, MSB digit of r first:
    //   p' = p * 2^DIGIT_W + a * digit, then bits >= 130 folded back as *5
    //   (2^130 == 5 mod p). With p, a < 2^131 the folded result stays < 2^131.
    // ------------------------------------------------------------------
    logic [DIGIT_W-1:0] digit;
    logic [WIDE-1:0]    mac_w;
    logic [DIGIT_W+1:0] hi_w;
    logic [FW-1:0]      five_hi;
    logic [130:0]       step_p;

    assign digit   = r_sh_q[127 -: DIGIT_W];
    assign mac_w   = {1'b0, p_q, {DIGIT_W{1'b0}}} + (WIDE'(a_q) * WIDE'(digit));
    assign hi_w    = mac_w[WIDE-1:130];
    assign five_hi = FW'({hi_w, 2'b00}) + FW'(hi_w);
    assign step_p  = {1'b0, mac_w[129:0]} + 131'(five_hi);

    // Closing fold: p < 2^131 -> fold1 < 2^130 + 5. A second fold only
    // fires when fold1 >= 2^130, in which case its low bits are < 5, so the
    // result is < 10 and fits in 130 bits without overflow.
    logic [130:0] fold1;
    logic [129:0] fold2;

    assign fold1 = {1'b0, p_q[129:0]} + 131'({p_q[130], 2'b00}) + 131'(p_q[130]);
    assign fold2 = fold1[129:0] + 130'({fold1[130], 2'b00}) + 130'(fold1[130]);

    // Canonical reduction before adding s; only the low 128 bits survive.
    logic [127:0] red_lo;
    logic [127:0] tag_fin;

    assign red_lo  = (acc_q >= P_MOD) ? 128'(acc_q - P_MOD) : acc_q[127:0];
    assign tag_fin = red_lo + s_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        p1305_if.msg_rdy = 1'b0;
        p1305_if.tag_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (p1305_if.key_vld) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                p1305_if.msg_rdy = 1'b1;
                if (p1305_if.msg_vld) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = last_q ? S_FINAL : S_READY;
                end
            end
            S_FINAL: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                p1305_if.tag_vld = 1'b1;
                if (p1305_if.tag_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // abort wins over any handshake in the same cycle
        if (p1305_if.abort) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_ni || p1305_if.abort) begin
            acc_q  <= '0;
            r_q    <= '0;
            s_q    <= '0;
            tag_q  <= '0;
            a_q    <= '0;
            p_q    <= '0;
            r_sh_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (p1305_if.key_vld) begin
                        r_q   <= p1305_if.key_r & R_CLAMP;
                        s_q   <= p1305_if.key_s;
                        acc_q <= '0;
                    end
                end
                S_READY: begin
                    if (p1305_if.msg_vld) begin
                        a_q    <= blk_sum;
                        p_q    <= '0;
                        r_sh_q <= r_q;
                        cnt_q  <= '0;
                        last_q <= p1305_if.msg_last;
                    end
                end
                S_MUL: begin
                    if (cnt_q != CNT_LAST) begin
                        p_q    <= step_p;
                        r_sh_q <= r_sh_q << DIGIT_W;
                        cnt_q  <= cnt_q + 1'b1;
                    end else begin
                        acc_q  <= fold2;
                    end
                end
                S_FINAL: begin
                    tag_q <= tag_fin;
                end
                S_OUT: begin
                    if (p1305_if.tag_rdy) begin
                        acc_q <= '0;
                        r_q   <= '0;
                        s_q   <= '0;
                        tag_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign p1305_if.tag = tag_q;

endmodule

// File: tb/tb_poly1305_stream.sv
// ---------------------------------------------------------------------------
// tb_poly1305_stream
//   Scoreboarded bench for poly1305_stream. Expected tags are computed with
//   a big-integer Poly1305 model ((h+n)*r mod 2^130-5) and queued when the
//   final block is accepted; a monitor pops and compares on every tag
//   handshake. Extra DIGIT_W=1 and 32 instances check block latency.
// ---------------------------------------------------------------------------
module tb_poly1305_stream;

    localparam int MC8 = 16;
    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [127:0] RFC_R = 128'h0806d5400e52447c036d555408bed685;
    localparam logic [127:0] RFC_S = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] RFC_T = 128'ha927010caf8b2bc2c6365130c11d06a8;

    logic clk;
    logic rst_ni;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat_done_cnt = 0;
    logic [127:0] sb_q[$];

    logic [127:0] mb[8];
    int           ml[8];

    poly1305_stream_if ifc();

    poly1305_stream #(.DIGIT_W(8)) u_dut (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .p1305_if (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [129:0] ref_step(input logic [129:0] h, input logic [127:0] r,
                                              input logic [127:0] blk, input int len);
        logic [263:0] n;
        logic [263:0] pm;
        logic [263:0] prod;
        n = '0;
        for (int i = 0; i < len; i++) n[8*i +: 8] = blk[8*i +: 8];
        n[8*len] = 1'b1;
        pm   = (264'(1) << 130) - 264'(5);
        prod = (264'(h) + n) * 264'(r);
        return 130'(prod % pm);
    endfunction

    function automatic logic [127:0] ref_tag(input logic [129:0] h, input logic [127:0] s);
        logic [130:0] t;
        t = {1'b0, h} + {3'b000, s};
        return t[127:0];
    endfunction

    function automatic logic [127:0] str_blk(input string s, input int off);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++)
            if (off + i < s.len()) v[8*i +: 8] = s[off+i];
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Monitor: a tag handshake will occur at the next rising edge.
    initial begin : monitor
        logic [127:0] e;
        int tag_no;
        tag_no = 0;
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1 && ifc.tag_vld === 1'b1 && ifc.tag_rdy === 1'b1 &&
                ifc.abort === 1'b0) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tag_unexpected got=%h required=none", ifc.tag);
                end else begin
                    e = sb_q.pop_front();
                    $display("tag %0d got=%h exp=%h", tag_no, ifc.tag, e);
                    chk($sformatf("tag%0d", tag_no), ifc.tag, e);
                end
                tag_no++;
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic load_key(input logic [127:0] kr, input logic [127:0] ks);
        ifc.key_r   = kr;
        ifc.key_s   = ks;
        ifc.key_vld = 1'b1;
        @(posedge clk);
        #1 ifc.key_vld = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] m, input int len, input logic last,
                              output int t0);
        ifc.msg      = m;
        ifc.msg_len  = 5'(len);
        ifc.msg_last = last;
        ifc.msg_vld  = 1'b1;
        t0 = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ifc.msg_rdy === 1'b1) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL msg_accept_timeout got=msg_rdy_low required=msg_rdy_high");
        end
        @(posedge clk);
        #1 ifc.msg_vld = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tag_timeout got=%0d_pending required=0", sb_q.size());
            sb_q.delete();
        end
        #1;
    endtask

    task automatic run_msg(input logic [127:0] kr, input logic [127:0] ks, input int nb,
                           input bit use_const, input logic [127:0] cexp);
        logic [129:0] h;
        int t;
        h = '0;
        load_key(kr, ks);
        for (int b = 0; b < nb; b++) begin
            send_block(mb[b], ml[b], (b == nb - 1), t);
            h = ref_step(h, kr & CLAMP, mb[b], ml[b]);
        end
        sb_q.push_back(use_const ? cexp : ref_tag(h, ks));
        wait_drain();
    endtask

    task automatic fill_rand(input int nb, input int last_len);
        for (int b = 0; b < nb; b++) begin
            mb[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ml[b] = 16;
        end
        ml[nb-1] = (last_len > 0) ? last_len : int'($urandom_range(1, 16));
    endtask

    task automatic load_rfc();
        string s;
        s = "Cryptographic Forum Research Group";
        mb[0] = str_blk(s, 0);  ml[0] = 16;
        mb[1] = str_blk(s, 16); ml[1] = 16;
        mb[2] = str_blk(s, 32); ml[2] = 2;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_seq
        logic [127:0] kr, ks, e;
        logic [129:0] h;
        int t0, d;
        ifc.key_vld = 0; ifc.key_r = '0; ifc.key_s = '0;
        ifc.msg_vld = 0; ifc.msg = '0; ifc.msg_len = '0; ifc.msg_last = 0;
        ifc.abort = 0; ifc.tag_rdy = 1'b1;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_msg_rdy", ifc.msg_rdy, 0);
        chk("reset_tag_vld", ifc.tag_vld, 0);
        chk("reset_tag", ifc.tag, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // RFC 8439 vector
        load_rfc();
        run_msg(RFC_R, RFC_S, 3, 1'b1, RFC_T);

        // r = 0 -> tag = s
        mb[0] = '1; ml[0] = 16;
        run_msg('0, 128'h0123456789abcdef0123456789abcdef, 1, 1'b1,
                128'h0123456789abcdef0123456789abcdef);
        run_msg('0, '1, 1, 1'b1, '1);

        // Latency with DIGIT_W = 8
        kr = {$urandom(), $urandom(), $urandom(), $urandom()};
        ks = {$urandom(), $urandom(), $urandom(), $urandom()};
        fill_rand(2, 16);
        load_key(kr, ks);
        send_block(mb[0], 16, 1'b0, t0);
        d = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ifc.msg_rdy === 1'b1) begin d = cyc - t0; break; end
        end
        chk_int("lat_rdy_dw8", d, MC8 + 2);
        @(posedge clk); #1;
        send_block(mb[1], 16, 1'b1, t0);
        h = ref_step(ref_step('0, kr & CLAMP, mb[0], 16), kr & CLAMP, mb[1], 16);
        sb_q.push_back(ref_tag(h, ks));
        d = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ifc.tag_vld === 1'b1) begin d = cyc - t0; break; end
        end
        chk_int("lat_tag_dw8", d, MC8 + 3);
        @(posedge clk); #1;
        wait_drain();

        // tag_rdy held low: tag stable, key/msg ignored
        ifc.tag_rdy = 1'b0;
        kr = {$urandom(), $urandom(), $urandom(), $urandom()};
        ks = {$urandom(), $urandom(), $urandom(), $urandom()};
        fill_rand(1, 7);
        load_key(kr, ks);
        send_block(mb[0], ml[0], 1'b1, t0);
        e = ref_tag(ref_step('0, kr & CLAMP, mb[0], ml[0]), ks);
        sb_q.push_back(e);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ifc.tag_vld === 1'b1) break;
        end
        @(posedge clk);
        #1;
        ifc.key_vld = 1'b1; ifc.key_r = '1; ifc.key_s = '1;
        ifc.msg_vld = 1'b1; ifc.msg_last = 1'b1; ifc.msg_len = 5'd16;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("hold_tag_vld", ifc.tag_vld, 1);
            chk("hold_tag", ifc.tag, e);
            chk("hold_msg_rdy", ifc.msg_rdy, 0);
        end
        @(posedge clk);
        #1 ifc.key_vld = 1'b0; ifc.msg_vld = 1'b0;
        @(posedge clk);
        #1 ifc.tag_rdy = 1'b1;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("no_key_after_tag", ifc.msg_rdy, 0);
        @(posedge clk); #1;

        // abort mid-MUL
        fill_rand(1, 16);
        load_key(kr, ks);
        send_block(mb[0], 16, 1'b1, t0);
        repeat (5) @(posedge clk);
        #1 ifc.abort = 1'b1;
        @(posedge clk);
        #1 ifc.abort = 1'b0;
        @(negedge clk);
        chk("abort_mul_msg_rdy", ifc.msg_rdy, 0);
        chk("abort_mul_tag_vld", ifc.tag_vld, 0);
        repeat (25) @(negedge clk);
        chk("abort_mul_no_tag", ifc.tag_vld, 0);
        @(posedge clk); #1;

        // abort together with a message handshake
        load_key(kr, ks);
        ifc.msg = mb[0]; ifc.msg_len = 5'd16; ifc.msg_last = 1'b1;
        ifc.msg_vld = 1'b1; ifc.abort = 1'b1;
        @(posedge clk);
        #1 ifc.msg_vld = 1'b0; ifc.abort = 1'b0;
        @(negedge clk);
        chk("abort_hs_msg_rdy", ifc.msg_rdy, 0);
        chk("abort_hs_tag_vld", ifc.tag_vld, 0);
        repeat (25) @(negedge clk);
        chk("abort_hs_no_tag", ifc.tag_vld, 0);
        @(posedge clk); #1;
        load_rfc();
        run_msg(RFC_R, RFC_S, 3, 1'b1, RFC_T);

        // reset during MUL
        fill_rand(1, 16);
        load_key(kr, ks);
        send_block(mb[0], 16, 1'b1, t0);
        repeat (4) @(posedge clk);
        #1 rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mul_msg_rdy", ifc.msg_rdy, 0);
        chk("rst_mul_tag_vld", ifc.tag_vld, 0);
        chk("rst_mul_tag", ifc.tag, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_rel_msg_rdy", ifc.msg_rdy, 0);
        @(posedge clk); #1;

        // randomized messages, including len=1 and len=15 final blocks
        for (int i = 0; i < 8; i++) begin
            int nb;
            nb = int'($urandom_range(1, 4));
            fill_rand(nb, (i == 0) ? 1 : ((i == 1) ? 15 : 0));
            kr = {$urandom(), $urandom(), $urandom(), $urandom()};
            ks = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_msg(kr, ks, nb, 1'b0, '0);
        end

        for (int k = 0; k < 5000; k++) begin
            if (lat_done_cnt == 2) break;
            @(posedge clk);
        end
        if (lat_done_cnt != 2) begin
            vectors++;
            miscompares++;
            $display("FAIL lat_instances got=%0d_done required=2", lat_done_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- latency instances for DIGIT_W = 1 and 32 ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_lat
        localparam int DW = (gi == 0) ? 1 : 32;
        localparam int MC = 128 / DW;

        poly1305_stream_if lif();
        logic lrst_n;

        poly1305_stream #(.DIGIT_W(DW)) u_lat (
            .clk      (clk),
            .rst_ni   (lrst_n),
            .p1305_if (lif)
        );

        initial begin : lat_seq
            logic [127:0] kr, ks, m0, m1, e;
            logic [129:0] h;
            int t0, d;
            lif.key_vld = 0; lif.key_r = '0; lif.key_s = '0;
            lif.msg_vld = 0; lif.msg = '0; lif.msg_len = '0; lif.msg_last = 0;
            lif.abort = 0; lif.tag_rdy = 1'b0;
            lrst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 lrst_n = 1'b1;
            kr = {$urandom(), $urandom(), $urandom(), $urandom()};
            ks = {$urandom(), $urandom(), $urandom(), $urandom()};
            m0 = {$urandom(), $urandom(), $urandom(), $urandom()};
            m1 = {$urandom(), $urandom(), $urandom(), $urandom()};
            lif.key_r = kr; lif.key_s = ks; lif.key_vld = 1'b1;
            @(posedge clk);
            #1 lif.key_vld = 1'b0;

            lif.msg = m0; lif.msg_len = 5'd16; lif.msg_last = 1'b0; lif.msg_vld = 1'b1;
            t0 = -1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (lif.msg_rdy === 1'b1) begin t0 = cyc; break; end
            end
            @(posedge clk);
            #1 lif.msg_vld = 1'b0;
            d = -1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (lif.msg_rdy === 1'b1) begin d = cyc - t0; break; end
            end
            chk_int($sformatf("lat_rdy_dw%0d", DW), d, MC + 2);

            @(posedge clk);
            #1;
            lif.msg = m1; lif.msg_len = 5'd9; lif.msg_last = 1'b1; lif.msg_vld = 1'b1;
            t0 = -1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (lif.msg_rdy === 1'b1) begin t0 = cyc; break; end
            end
            @(posedge clk);
            #1 lif.msg_vld = 1'b0;
            d = -1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (lif.tag_vld === 1'b1) begin d = cyc - t0; break; end
            end
            chk_int($sformatf("lat_tag_dw%0d", DW), d, MC + 3);
            h = ref_step(ref_step('0, kr & CLAMP, m0, 16), kr & CLAMP, m1, 9);
            e = ref_tag(h, ks);
            $display("lat tag dw%0d got=%h exp=%h", DW, lif.tag, e);
            chk($sformatf("lat_tag_val_dw%0d", DW), lif.tag, e);
            @(posedge clk);
            #1 lif.tag_rdy = 1'b1;
            @(posedge clk);
            #1 lif.tag_rdy = 1'b0;
            lat_done_cnt++;
        end
    end

endmodule
